sec_and_dw: RTL and testbench

SEC_AND_DW -- requirements
Module: sec_and_dw

---
 rtl/sec_and_pkg.sv | 20 ++
 rtl/sec_and_dw_if.sv | 31 +++
 rtl/sec_and_pair.sv | 35 +++
 rtl/sec_and_dw.sv | 119 +++++++++++
 tb/tb_sec_and_dw.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/sec_and_pkg.sv
// Shared state encoding and pair-index helpers for the masked AND gadget.
package sec_and_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PA   = 2'd1,
        ST_PB   = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    function automatic int npairs(input int d);
        return d * (d - 1) / 2;
    endfunction

    // Position of pair (i,j), i<j, in the order (0,1),(0,2),..,(0,d-1),(1,2),...
    function automatic int pidx(input int i, input int j, input int d);
        return i * d - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/sec_and_dw_if.sv
// Operand/result handshake bundle of the masked AND; master drives operands.
interface sec_and_dw_if #(
    parameter int W = 8,
    parameter int D = 2
);
    import sec_and_pkg::*;

    localparam int NPAIRS = npairs(D);

    logic                  clear_i;
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [W*D-1:0]        x_i;
    logic [W*D-1:0]        y_i;
    logic [W*NPAIRS-1:0]   r_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [W*D-1:0]        z_o;
    logic                  busy_o;

    modport master (
        output clear_i, in_valid_i, x_i, y_i, r_i, out_ready_i,
        input  in_ready_o, out_valid_o, z_o, busy_o
    );

    modport slave (
        input  clear_i, in_valid_i, x_i, y_i, r_i, out_ready_i,
        output in_ready_o, out_valid_o, z_o, busy_o
    );

endinterface

// File: rtl/sec_and_pair.sv
// One cross-share pair (i,j): registers t in phase A, then folds the mirror product into u in phase B.
module sec_and_pair #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         en_a,
    input  logic         en_b,
    input  logic [W-1:0] r,
    input  logic [W-1:0] xi,
    input  logic [W-1:0] yj,
    input  logic [W-1:0] xj,
    input  logic [W-1:0] yi,
    output logic [W-1:0] u
);

    logic [W-1:0] t;

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    // NOTE: the async reset clears t and u as well, so no stale share survives an aborted operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t <= '0;
            u <= '0;
        end else if (clear) begin
            t <= '0;
            u <= '0;
        end else begin
            if (en_a) t <= r ^ (xi & yj);
            if (en_b) u <= t ^ (xj & yi);
        end
    end

endmodule

// File: rtl/sec_and_dw.sv
// Domain-oriented masked AND over D shares of W bits, three cycles per operation.
module sec_and_dw
    import sec_and_pkg::*;
#(
    parameter int W = 8,
    parameter int D = 2
) (
    input logic         clk_i,
    input logic         rst_ni,
    sec_and_dw_if.slave bus
);

    localparam int NPAIRS = npairs(D);

    if (D < 2 || D > 4) begin : g_bad_d
        $error("sec_and_dw: share count D=%0d outside 2..4", D);
    end
    if (W < 1) begin : g_bad_w
        $error("sec_and_dw: share width W=%0d must be positive", W);
    end

    state_e       state;
    logic [W-1:0] x_q   [D];
    logic [W-1:0] y_q   [D];
    logic [W-1:0] z_q   [D];
    logic [W-1:0] z_own [D];
    logic [W-1:0] r_q   [NPAIRS];
    logic [W-1:0] u_q   [NPAIRS];
    logic [W*D-1:0] z_flat;
    logic accept;
    logic phase_a;
    logic phase_b;

    assign bus.in_ready_o  = (state == ST_IDLE) || ((state == ST_OUT) && bus.out_ready_i);
    assign bus.out_valid_o = (state == ST_OUT);
    assign bus.busy_o      = (state != ST_IDLE);
    assign accept          = bus.in_valid_i && bus.in_ready_o;
    assign phase_a         = (state == ST_PA);
    assign phase_b         = (state == ST_PB);

    // Own-domain term plus the randomness this share contributes to pairs where it is the lower index.
    always_comb begin
        for (int k = 0; k < D; k++) begin
            z_own[k] = x_q[k] & y_q[k];
            for (int j = k + 1; j < D; j++) begin
                z_own[k] = z_own[k] ^ r_q[pidx(k, j, D)];
            end
        end
    end

    // NOTE: the operand and result arrays are plain flops, so they are reset like any other state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
            x_q   <= '{default: '0};
            y_q   <= '{default: '0};
            r_q   <= '{default: '0};
            z_q   <= '{default: '0};
        end else if (bus.clear_i) begin
            state <= ST_IDLE;
            x_q   <= '{default: '0};
            y_q   <= '{default: '0};
            r_q   <= '{default: '0};
            z_q   <= '{default: '0};
        end else if (accept) begin
            for (int k = 0; k < D; k++) begin
                x_q[k] <= bus.x_i[k*W +: W];
                y_q[k] <= bus.y_i[k*W +: W];
            end
            for (int p = 0; p < NPAIRS; p++) begin
                r_q[p] <= bus.r_i[p*W +: W];
            end
            state <= ST_PA;
        end else begin
            case (state)
                ST_PA:   state <= ST_PB;
                ST_PB: begin
                    state <= ST_OUT;
                    z_q   <= z_own;
                end
                ST_OUT:  if (bus.out_ready_i) state <= ST_IDLE;
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < D; i++) begin : g_row
        for (genvar j = i + 1; j < D; j++) begin : g_col
            sec_and_pair #(.W(W)) u_pair (
                .clk   (clk_i),
                .rst_n (rst_ni),
                .clear (bus.clear_i),
                .en_a  (phase_a),
                .en_b  (phase_b),
                .r     (r_q[pidx(i, j, D)]),
                .xi    (x_q[i]),
                .yj    (y_q[j]),
                .xj    (x_q[j]),
                .yi    (y_q[i]),
                .u     (u_q[pidx(i, j, D)])
            );
        end
    end

    // Result shares combine only registered values: z_q and the u registers of lower-index pairs.
    // NOTE: z_flat gets a full default before the loop so no bit is left unassigned (no latch).
    always_comb begin
        z_flat = '0;
        for (int k = 0; k < D; k++) begin
            z_flat[k*W +: W] = z_q[k];
            for (int j = 0; j < k; j++) begin
                z_flat[k*W +: W] = z_flat[k*W +: W] ^ u_q[pidx(j, k, D)];
            end
        end
    end

    assign bus.z_o = z_flat;

endmodule

// File: tb/tb_sec_and_dw.sv
// Directed self-checking bench: a D=2/W=1 and a D=3/W=8 instance share clock and reset.
module tb_sec_and_dw;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    sec_and_dw_if #(.W(1), .D(2)) bus2 ();
    sec_and_dw_if #(.W(8), .D(3)) bus3 ();

    sec_and_dw #(.W(1), .D(2)) dut2 (.clk_i(clk), .rst_ni(rst_n), .bus(bus2));
    sec_and_dw #(.W(8), .D(3)) dut3 (.clk_i(clk), .rst_ni(rst_n), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no end of run, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] share3(input logic [7:0] v);
        logic [7:0] a;
        logic [7:0] b;
        a = 8'($urandom);
        b = 8'($urandom);
        return {v ^ a ^ b, b, a};
    endfunction

    function automatic logic [7:0] unmask3(input logic [23:0] s);
        return s[7:0] ^ s[15:8] ^ s[23:16];
    endfunction

    task automatic op2(input logic [1:0] x, input logic [1:0] y, input logic r);
        logic [1:0] z;
        logic       exp;
        bus2.x_i = x; bus2.y_i = y; bus2.r_i = r; bus2.in_valid_i = 1'b1;
        tick();
        bus2.in_valid_i = 1'b0;
        tick();
        tick();
        check("d2_out_valid", 32'(bus2.out_valid_o), 32'd1);
        z   = bus2.z_o;
        exp = (x[0] ^ x[1]) & (y[0] ^ y[1]);
        check("d2_and", 32'(z[0] ^ z[1]), 32'(exp));
        bus2.out_ready_i = 1'b1;
        tick();
        bus2.out_ready_i = 1'b0;
    endtask

    // Full operation on the D=3 instance from IDLE, checking latency and the unmasked result.
    task automatic op3(input logic [7:0] xv, input logic [7:0] yv, input logic [7:0] exp);
        bus3.x_i = share3(xv); bus3.y_i = share3(yv); bus3.r_i = 24'($urandom);
        bus3.in_valid_i = 1'b1;
        #1;
        check("d3_in_ready", 32'(bus3.in_ready_o), 32'd1);
        tick();
        bus3.in_valid_i = 1'b0;
        check("d3_pa_valid", 32'(bus3.out_valid_o), 32'd0);
        tick();
        check("d3_pb_valid", 32'(bus3.out_valid_o), 32'd0);
        tick();
        check("d3_out_valid", 32'(bus3.out_valid_o), 32'd1);
        check("d3_and", 32'(unmask3(bus3.z_o)), 32'(exp));
        bus3.out_ready_i = 1'b1;
        tick();
        bus3.out_ready_i = 1'b0;
        check("d3_idle_busy", 32'(bus3.busy_o), 32'd0);
    endtask

    logic [7:0]  bx   [4] = '{8'hFF, 8'h5A, 8'h81, 8'hC3};
    logic [7:0]  by   [4] = '{8'h0F, 8'hF0, 8'h7E, 8'hE7};
    logic [7:0]  bexp [4] = '{8'h0F, 8'h50, 8'h00, 8'hC3};
    logic [23:0] zhold;

    initial begin
        rst_n = 1'b1;
        bus2.clear_i = 1'b0; bus2.in_valid_i = 1'b0; bus2.out_ready_i = 1'b0;
        bus2.x_i = '0; bus2.y_i = '0; bus2.r_i = '0;
        bus3.clear_i = 1'b0; bus3.in_valid_i = 1'b0; bus3.out_ready_i = 1'b0;
        bus3.x_i = '0; bus3.y_i = '0; bus3.r_i = '0;
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("rst2_in_ready",  32'(bus2.in_ready_o),  32'd1);
        check("rst2_out_valid", 32'(bus2.out_valid_o), 32'd0);
        check("rst2_busy",      32'(bus2.busy_o),      32'd0);
        check("rst2_z",         32'(bus2.z_o),         32'd0);
        check("rst3_in_ready",  32'(bus3.in_ready_o),  32'd1);
        check("rst3_out_valid", 32'(bus3.out_valid_o), 32'd0);
        check("rst3_busy",      32'(bus3.busy_o),      32'd0);
        check("rst3_z",         32'(bus3.z_o),         32'd0);
        rst_n = 1'b1;
        tick();

        // All 16 share combinations of the 1-bit, 2-share instance with both randomness values.
        for (int xs = 0; xs < 4; xs++) begin
            for (int ys = 0; ys < 4; ys++) begin
                for (int rv = 0; rv < 2; rv++) begin
                    op2(2'(xs), 2'(ys), 1'(rv));
                end
            end
        end

        // 0xA5 & 0x3C = 0x24 under fresh sharings.
        for (int n = 0; n < 1000; n++) begin
            op3(8'hA5, 8'h3C, 8'h24);
        end

        // Backpressure: result and handshake held while the consumer stalls.
        bus3.x_i = share3(8'hF0); bus3.y_i = share3(8'h3C); bus3.r_i = 24'($urandom);
        bus3.in_valid_i = 1'b1;
        tick();
        bus3.in_valid_i = 1'b0;
        tick();
        tick();
        check("bp_out_valid", 32'(bus3.out_valid_o), 32'd1);
        check("bp_and", 32'(unmask3(bus3.z_o)), 32'h30);
        zhold = bus3.z_o;
        bus3.x_i = share3(8'h11); bus3.y_i = share3(8'h11); bus3.in_valid_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_z_stable",  32'(bus3.z_o),         32'(zhold));
            check("bp_in_ready",  32'(bus3.in_ready_o),  32'd0);
            check("bp_out_valid", 32'(bus3.out_valid_o), 32'd1);
        end
        bus3.in_valid_i = 1'b0;
        bus3.out_ready_i = 1'b1;
        #1;
        check("bp_ready_on_handshake", 32'(bus3.in_ready_o), 32'd1);
        tick();
        bus3.out_ready_i = 1'b0;
        check("bp_after_valid", 32'(bus3.out_valid_o), 32'd0);
        check("bp_after_busy",  32'(bus3.busy_o),      32'd0);
        check("bp_after_z",     32'(bus3.z_o),         32'(zhold));

        // Back-to-back: valid and ready held high, one result every third cycle.
        bus3.out_ready_i = 1'b1;
        bus3.x_i = share3(bx[0]); bus3.y_i = share3(by[0]); bus3.r_i = 24'($urandom);
        bus3.in_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i < 3) begin
                bus3.x_i = share3(bx[i+1]); bus3.y_i = share3(by[i+1]); bus3.r_i = 24'($urandom);
            end else begin
                bus3.in_valid_i = 1'b0;
            end
            check("b2b_pa_valid", 32'(bus3.out_valid_o), 32'd0);
            tick();
            check("b2b_pb_valid", 32'(bus3.out_valid_o), 32'd0);
            tick();
            check("b2b_out_valid", 32'(bus3.out_valid_o), 32'd1);
            check("b2b_and", 32'(unmask3(bus3.z_o)), 32'(bexp[i]));
        end
        tick();
        bus3.out_ready_i = 1'b0;
        check("b2b_end_busy", 32'(bus3.busy_o), 32'd0);

        // Clear during phase B aborts the operation.
        bus3.x_i = share3(8'hA5); bus3.y_i = share3(8'h3C); bus3.r_i = 24'($urandom);
        bus3.in_valid_i = 1'b1;
        tick();
        bus3.in_valid_i = 1'b0;
        tick();
        check("clr_in_pb_busy", 32'(bus3.busy_o), 32'd1);
        bus3.clear_i = 1'b1;
        tick();
        bus3.clear_i = 1'b0;
        check("clr_busy",      32'(bus3.busy_o),      32'd0);
        check("clr_out_valid", 32'(bus3.out_valid_o), 32'd0);
        check("clr_z",         32'(bus3.z_o),         32'd0);
        check("clr_in_ready",  32'(bus3.in_ready_o),  32'd1);
        tick();
        check("clr_no_valid_1", 32'(bus3.out_valid_o), 32'd0);
        tick();
        check("clr_no_valid_2", 32'(bus3.out_valid_o), 32'd0);

        // Reset pulsed during phase A, after a result has left nonzero shares on z_o.
        op3(8'h77, 8'hEE, 8'h66);
        bus3.x_i = share3(8'hA5); bus3.y_i = share3(8'h3C); bus3.r_i = 24'($urandom);
        bus3.in_valid_i = 1'b1;
        tick();
        bus3.in_valid_i = 1'b0;
        check("rstpa_busy_before", 32'(bus3.busy_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstpa_in_ready",  32'(bus3.in_ready_o),  32'd1);
        check("rstpa_out_valid", 32'(bus3.out_valid_o), 32'd0);
        check("rstpa_busy",      32'(bus3.busy_o),      32'd0);
        check("rstpa_z",         32'(bus3.z_o),         32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rstpa_no_valid_1", 32'(bus3.out_valid_o), 32'd0);
        tick();
        check("rstpa_no_valid_2", 32'(bus3.out_valid_o), 32'd0);
        op3(8'hA5, 8'h3C, 8'h24);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
